// File: rtl/axi_burst_slave_mem.sv
// AXI4 INCR-burst responder over a flop word array; independent read and write engines.
// Optional macro RD_LAT_EN inserts an RD_LAT-cycle wait between AR acceptance and the first R beat.
module axi_burst_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [6:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [6:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);
  localparam int         IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_WIDTH/8));

`ifdef RD_LAT_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} rstate_t;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  rstate_t r_rstate, w_rnext;
  wstate_t r_wstate, w_wnext;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [ID_WIDTH-1:0]   r_rid, r_wid;
  logic [IDX_W-1:0]      r_ridx, r_widx;
  logic [6:0]            r_rrem, r_wrem;
  logic                  r_rerr, r_werr;
  logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs;
`ifdef RD_LAT_EN
  logic [7:0]            r_rwait;
`endif

  // Address bits outside the word index and the burst type play no part.
  logic w_unused;
  assign w_unused = ^{arburst, awburst, araddr[0], awaddr[0],
                      araddr[ADDR_WIDTH-1:IDX_W+1], awaddr[ADDR_WIDTH-1:IDX_W+1], RD_LAT[0]};

  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  // ---------------- read engine ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
`ifdef RD_LAT_EN
      R_IDLE:  if (arvalid) w_rnext = R_WAIT;
      R_WAIT:  if (r_rwait == 8'd0) w_rnext = R_DATA;
`else
      R_IDLE:  if (arvalid) w_rnext = R_DATA;
`endif
      R_DATA:  if (rready && r_rrem == 7'd0) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read data comes straight off the array, so a same-cycle write is seen only next cycle.
  always_comb begin
    arready = (r_rstate == R_IDLE);
    rvalid  = (r_rstate == R_DATA);
    rlast   = rvalid && (r_rrem == 7'd0);
    rid     = rvalid ? r_rid : '0;
    rresp   = (rvalid && r_rerr) ? 2'b10 : 2'b00;
    rdata   = rvalid ? r_mem[r_ridx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rid  <= '0;
      r_ridx <= '0;
      r_rrem <= '0;
      r_rerr <= 1'b0;
`ifdef RD_LAT_EN
      r_rwait <= '0;
`endif
    end else if (w_ar_hs) begin
      r_rid  <= arid;
      r_ridx <= araddr[IDX_W:1];
      r_rrem <= arlen;
      r_rerr <= (arsize != SIZE_OK);
`ifdef RD_LAT_EN
      r_rwait <= 8'(RD_LAT - 1);
`endif
    end else if (w_r_hs) begin
      r_ridx <= r_ridx + 1'b1;
      r_rrem <= r_rrem - 7'd1;
`ifdef RD_LAT_EN
    end else if (r_rstate == R_WAIT) begin
      r_rwait <= r_rwait - 8'd1;
`endif
    end

  // ---------------- write engine ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (awvalid) w_wnext = W_DATA;
      W_DATA:  if (wvalid && r_wrem == 7'd0) w_wnext = W_RESP;
      W_RESP:  if (bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (r_wstate == W_IDLE);
    wready  = (r_wstate == W_DATA);
    bvalid  = (r_wstate == W_RESP);
    bid     = bvalid ? r_wid : '0;
    bresp   = (bvalid && r_werr) ? 2'b10 : 2'b00;
  end

  // Beat count alone ends the burst; a misplaced wlast only poisons the response.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wid  <= '0;
      r_widx <= '0;
      r_wrem <= '0;
      r_werr <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid  <= awid;
      r_widx <= awaddr[IDX_W:1];
      r_wrem <= awlen;
      r_werr <= (awsize != SIZE_OK);
    end else if (w_w_hs) begin
      r_widx <= r_widx + 1'b1;
      r_wrem <= r_wrem - 7'd1;
      if (wlast != (r_wrem == 7'd0)) r_werr <= 1'b1;
    end

  always_ff @(posedge clk)
    if (w_w_hs) r_mem[r_widx] <= wdata;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: burst writes, read-back, wrap, wlast/size errors, stalls, reset abort.
module tb_axi_burst_slave_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr;
  logic [6:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [15:0] rdata, wdata;

  int ntot = 0, npass = 0, nfail = 0;

`ifdef RD_LAT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  axi_burst_slave_mem dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [6:0] len,
                          input logic [2:0] size, input logic [15:0] base, input int wlast_at,
                          input logic [1:0] exp_resp);
    chk("awready_idle", awready, 1);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    chk("awready_busy", awready, 0);
    chk("wready_on", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + 16'(i); wlast = (i == wlast_at); wvalid = 1'b1;
      cyc();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wready_off", wready, 0);
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    cyc();
    chk("bvalid_held", bvalid, 1);
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("bvalid_done", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [6:0] len,
                         input logic [2:0] size, input logic [15:0] base, input logic [1:0] exp_resp,
                         input bit stall);
    int lat;
    chk("arready_idle", arready, 1);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b0;
    cyc();
    arvalid = 1'b0;
    chk("arready_busy", arready, 0);
    lat = 1;
    while (!rvalid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("rd_latency", lat, EXP_LAT);
    for (int i = 0; i <= int'(len); i++) begin
      if (stall) begin
        chk("stall_rvalid", rvalid, 1);
        cyc();
        chk("stall_rdata", rdata, base + 16'(i));
        chk("stall_rlast", rlast, (i == int'(len)));
      end
      rready = 1'b1;
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, base + 16'(i));
      chk("rlast", rlast, (i == int'(len)));
      chk("rid", rid, id);
      chk("rresp", rresp, exp_resp);
      cyc();
      rready = 1'b0;
    end
    chk("rvalid_done", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    rst_n = 1'b1;
    cyc();

    // T1/T2: 4-beat write to words 8..11 and read-back
    do_write(4'd3, 32'h10, 7'd3, 3'd1, 16'h00A0, 3, 2'b00);
    do_read (4'd5, 32'h10, 7'd3, 3'd1, 16'h00A0, 2'b00, 1'b0);

    // T3: two-beat burst across the top of memory, words 255 then 0
    do_write(4'd1, 32'h1FE, 7'd1, 3'd1, 16'h1234, 1, 2'b00);
    do_read (4'd2, 32'h1FE, 7'd1, 3'd1, 16'h1234, 2'b00, 1'b0);

    // T4: early wlast still takes all 3 beats, response SLVERR
    do_write(4'd7, 32'h40, 7'd2, 3'd1, 16'h00B0, 1, 2'b10);
    do_read (4'd6, 32'h40, 7'd2, 3'd1, 16'h00B0, 2'b00, 1'b0);

    // Bad size: data moves, response SLVERR
    do_write(4'd9, 32'h60, 7'd0, 3'd2, 16'h0DD0, 0, 2'b10);
    do_read (4'd4, 32'h60, 7'd0, 3'd0, 16'h0DD0, 2'b10, 1'b0);

    // T5: 8-beat read with rready toggling
    do_write(4'd2, 32'h100, 7'd7, 3'd1, 16'h00C0, 7, 2'b00);
    do_read (4'd8, 32'h100, 7'd7, 3'd1, 16'h00C0, 2'b00, 1'b1);

    // T6: reset during third beat of an 8-beat write
    awid = 4'd5; awaddr = 32'h200; awlen = 7'd7; awsize = 3'd1; awburst = 2'b01; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 16'hE0 + 16'(i); wvalid = 1'b1;
      cyc();
    end
    wdata = 16'hE2; wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arready", arready, 1);
    chk("t6_awready", awready, 1);
    chk("t6_bvalid", bvalid, 0);
    chk("t6_wready", wready, 0);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    do_write(4'd6, 32'h200, 7'd1, 3'd1, 16'h00F0, 1, 2'b00);
    do_read (4'd6, 32'h200, 7'd1, 3'd1, 16'h00F0, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
